// File: rtl/pc_next_pkg.sv
// pc_next_pkg: shared state encoding and constants for the fetch-stage PC unit
package pc_next_pkg;
  typedef enum logic [1:0] {RUN, BR_WAIT, BR_HOLD} state_t;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/pc_adder32.sv
// pc_adder32: 32-bit wrap-around adder
module pc_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: fetch PC register with branch/J/JR next-PC select; PCNU_MISALIGN_CHECK_EN traps misaligned JR
module pc_next_unit
  import pc_next_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          WIDTH    = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchBase,
  input  logic [WIDTH-1:0] ShiftedOff,
  input  logic             Jump,
  input  logic [25:0]      JumpIdx,
  input  logic             JumpReg,
  input  logic [WIDTH-1:0] JrTarget,
  output logic [WIDTH-1:0] Pc,
  output logic [WIDTH-1:0] PcPlus4,
  output logic             FetchValid,
  output logic             Flush,
`ifdef PCNU_MISALIGN_CHECK_EN
  output logic             MisalignErr,
`endif
  output logic             Busy
);
  state_t state, state_nxt;
  logic [31:0] pc_nxt, pc_inc, br_tgt, base_q, base_nxt, tgt_q, tgt_nxt, jr_tgt;
  logic fv_nxt, flush_nxt, err, err_nxt, jr_bad;
  pc_adder32 u_inc (.a(pc_nxt), .b(INSTR_BYTES), .sum(pc_inc));
  pc_adder32 u_br  (.a(base_q), .b(ShiftedOff), .sum(br_tgt));
`ifdef PCNU_MISALIGN_CHECK_EN
  assign err    = MisalignErr;
  assign jr_bad = JrTarget[1:0] != 2'b00;
  assign jr_tgt = JrTarget;
`else
  assign err    = 1'b0;
  assign jr_bad = 1'b0;
  assign jr_tgt = JrTarget & ~32'd3;
`endif
  assign Busy = state != RUN;
  always_comb begin
    state_nxt = state;
    pc_nxt    = Pc;
    base_nxt  = base_q;
    tgt_nxt   = tgt_q;
    fv_nxt    = FetchValid;
    flush_nxt = 1'b0;
    err_nxt   = err;
    case (state)
      RUN: if (!Stall) begin
        if (BranchTaken) begin
          base_nxt  = BranchBase;
          fv_nxt    = 1'b0;
          state_nxt = BR_WAIT;
        end else if (JumpReg && jr_bad) begin
          err_nxt = 1'b1;
          fv_nxt  = 1'b0;
        end else if (JumpReg) begin
          pc_nxt    = jr_tgt;
          flush_nxt = 1'b1;
          fv_nxt    = !err;
        end else if (Jump) begin
          pc_nxt    = {PcPlus4[31:28], JumpIdx, 2'b00};
          flush_nxt = 1'b1;
          fv_nxt    = !err;
        end else begin
          pc_nxt = PcPlus4;
          fv_nxt = !err;
        end
      end
      // the shifter output is only valid here, so capture it even when stalled
      BR_WAIT: begin
        tgt_nxt = br_tgt;
        if (!Stall) begin
          pc_nxt    = br_tgt;
          flush_nxt = 1'b1;
          fv_nxt    = !err;
          state_nxt = RUN;
        end else
          state_nxt = BR_HOLD;
      end
      BR_HOLD: if (!Stall) begin
        pc_nxt    = tgt_q;
        flush_nxt = 1'b1;
        fv_nxt    = !err;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state      <= RUN;
      Pc         <= RESET_PC;
      PcPlus4    <= RESET_PC + INSTR_BYTES;
      FetchValid <= 1'b0;
      Flush      <= 1'b0;
      base_q     <= '0;
      tgt_q      <= '0;
    end else begin
      state      <= state_nxt;
      Pc         <= pc_nxt;
      PcPlus4    <= pc_inc;
      FetchValid <= fv_nxt;
      Flush      <= flush_nxt;
      base_q     <= base_nxt;
      tgt_q      <= tgt_nxt;
    end
`ifdef PCNU_MISALIGN_CHECK_EN
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) MisalignErr <= 1'b0;
    else     MisalignErr <= err_nxt;
`else
  logic unused_err;
  assign unused_err = err_nxt;
`endif
endmodule
